sprite_blit_ctrl: RTL and testbench
===================================

// Module: sprite_blit_ctrl
// PURPOSE
//  Copies fixed-size card sprites from sprite ROM into the framebuffer image RAM that the VGA controller scans out.
//  Takes one blit command at a time over a valid/ready handshake: screen x/y and sprite id.
//  Streams one pixel per cycle and writes only while write_window is high, i.e. while the scanout is not reading.
//  Sits between the game CPU's MMIO command port and the write port of the framebuffer RAM.
// PARAMETERS
//  SCREEN_W     640  framebuffer width (pixels)
//  SCREEN_H     480  framebuffer height (pixels)
//  SPRITE_W     32   sprite width (pixels)
//  SPRITE_H     48   sprite height (pixels)
//  ID_W         6    sprite id width (up to 64 sprites)
//  FB_AW        20   framebuffer address width
//  ROM_AW       17   sprite ROM address width; must cover 2^ID_W*SPRITE_W*SPRITE_H
//  PIX_W        9    palette index width (framebuffer/ROM data)
//  TRANSPARENT  0    palette index that is never written
// PORTS
//  clk           in   1       pixel/system clock
//  reset         in   1       asynchronous, active-low reset
//  cmd_valid     in   1       command present
//  cmd_ready     out  1       block idle, command accepted when valid&ready
//  cmd_x         in   10      sprite left edge, screen x
//  cmd_y         in   9       sprite top edge, screen y
//  cmd_id        in   ID_W    sprite index
//  write_window  in   1       1 = framebuffer write permitted (blanking)
//  rom_addr      out  ROM_AW  sprite ROM address, registered
//  rom_data      in   PIX_W   ROM data, valid 1 cycle after rom_addr
//  fb_addr       out  FB_AW   framebuffer write address
//  fb_data       out  PIX_W   framebuffer write data
//  fb_wEn        out  1       framebuffer write enable
//  busy          out  1       command in progress
//  done          out  1       one-cycle pulse, command complete
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; every output 0, including cmd_ready; no write issued.
//  Reset asserted mid-blit aborts the blit; partially drawn pixels remain in RAM.
//  Reset release: cmd_ready=1 on the first clk edge.
//  States:
//   IDLE: cmd_ready=1. On valid&ready, latch x/y/id, clear counters -> COPY.
//   COPY: busy=1, cmd_ready=0. Fetch and commit pipeline below.
//    When commit completes pixel SPRITE_W*SPRITE_H-1 -> DONE.
//   DONE: done=1 and cmd_ready=1 for one cycle; busy=0.
//    A command valid in this cycle is accepted (-> COPY); otherwise -> IDLE.
//  Counters: fetch (fx,fy) and commit (cx,cy); each walks x-first, wraps at SPRITE_W, then increments y.
//  Fetch: rom_addr = id*SPRITE_W*SPRITE_H + fy*SPRITE_W + fx.
//   Fetch advances only when write_window=1.
//   p_valid <= write_window & fetch not exhausted.
//  Commit, when p_valid=1:
//   write_window=1: commit (cx,cy) and advance commit counter.
//    fb_wEn=1 unless rom_data==TRANSPARENT, or cmd_x+cx>=SCREEN_W, or cmd_y+cy>=SCREEN_H (clipped).
//    Suppressed pixels still advance the commit counter.
//   write_window=0: no write; fetch counter <= commit counter (replay).
//  fb_addr = (cmd_y+cy)*SCREEN_W + cmd_x+cx, computed at full width before truncation to FB_AW.
//  fb_wEn/fb_addr/fb_data are combinational from registered state and rom_data; fb_addr/fb_data are 0 when fb_wEn=0.
//  Latency: accept at edge T; first rom_addr in cycle T+1; first fb_wEn in T+2.
//   Last write in T+N+1 (N=SPRITE_W*SPRITE_H); done in T+N+2. Assumes write_window stays high.
//  Off-screen command (cmd_x>=SCREEN_W or cmd_y>=SCREEN_H): accepted; runs full length with zero writes; done as normal.
//  cmd_valid while busy is ignored. No ordering or queue beyond one command.
// STRUCTURE
//  Shared include blit_defs.vh: SCREEN_W/H, SPRITE_W/H, TRANSPARENT, state encodings IDLE/COPY/DONE.
//  Sub-module blit_addr_gen: counter pair plus rom_addr/fb_addr/clip arithmetic.
//  Top level holds FSM, handshake and write gating.
// TESTING
//  1 Reset low mid-COPY -> fb_wEn=0 and cmd_ready=0 immediately; cmd_ready=1 after release edge.
//  2 window=1, cmd (0,0,id=1) accepted at T -> rom_addr=1536 at T+1; fb_wEn at T+2 with fb_addr 0;
//    last write T+1537, fb_addr=47*640+31=30111; done at T+1538.
//  3 ROM with all pixels=0 except pixel 5=9'h1A7 -> exactly one write: fb_addr=cmd base+5, fb_data=9'h1A7.
//  4 cmd (620,470) -> writes only x 620..639, y 470..479 (200 writes); done still at T+1538.
//  5 window toggles 10 on / 3 off repeatedly -> no fb_wEn while window=0;
//    every non-transparent pixel written exactly once at the correct address.
//  6 cmd_valid held high through DONE -> second command accepted in the done cycle; busy stays high.

Source files
------------

// File: rtl/sprite_blit_ctrl_pkg.sv
// Shared types and constants for the sprite blitter: FSM states, command field widths
// and a counter-width helper.
package sprite_blit_ctrl_pkg;

  localparam int unsigned CMD_X_W = 10;
  localparam int unsigned CMD_Y_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COPY = 2'd1,
    ST_DONE = 2'd2
  } blit_state_e;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_blit_ctrl_if.sv
// Blit command port: screen position plus sprite id over a valid/ready handshake.
interface sprite_blit_ctrl_if
  import sprite_blit_ctrl_pkg::*;
#(
  parameter int unsigned ID_W = 6
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [CMD_X_W-1:0] cmd_x;
  logic [CMD_Y_W-1:0] cmd_y;
  logic [ID_W-1:0]    cmd_id;

  modport master (output cmd_valid, cmd_x, cmd_y, cmd_id, input cmd_ready);
  modport slave  (input cmd_valid, cmd_x, cmd_y, cmd_id, output cmd_ready);
endinterface

// File: rtl/sprite_blit_ctrl_addr_gen.sv
// Fetch/commit counter pair for one sprite, registered ROM address, and framebuffer
// address/clip arithmetic for the pixel currently being committed.
module sprite_blit_ctrl_addr_gen
  import sprite_blit_ctrl_pkg::*;
#(
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480,
  parameter int unsigned SPRITE_W = 32,
  parameter int unsigned SPRITE_H = 48,
  parameter int unsigned ID_W     = 6,
  parameter int unsigned FB_AW    = 20,
  parameter int unsigned ROM_AW   = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [CMD_X_W-1:0] cmd_x_i,
  input  logic [CMD_Y_W-1:0] cmd_y_i,
  input  logic [ID_W-1:0]    cmd_id_i,
  input  logic               fetch_adv_i,
  input  logic               commit_adv_i,
  input  logic               replay_i,
  output logic [ROM_AW-1:0]  rom_addr_o,
  output logic [FB_AW-1:0]   fb_addr_o,
  output logic               clip_o,
  output logic               fetch_exh_o,
  output logic               commit_last_o
);

  localparam int unsigned XW         = cnt_w(SPRITE_W);
  localparam int unsigned YW         = cnt_w(SPRITE_H + 1);
  localparam int unsigned SPRITE_PIX = SPRITE_W * SPRITE_H;

  logic [CMD_X_W-1:0] x_q, x_d;
  logic [CMD_Y_W-1:0] y_q, y_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [XW-1:0]      fx_q, fx_d, cx_q, cx_d;
  logic [YW-1:0]      fy_q, fy_d, cy_q, cy_d;
  logic [ROM_AW-1:0]  rom_addr_q, rom_addr_d;
  logic [31:0]        px, py;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      id_q       <= '0;
      fx_q       <= '0;
      fy_q       <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      rom_addr_q <= '0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      id_q       <= id_d;
      fx_q       <= fx_d;
      fy_q       <= fy_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    id_d = id_q;
    fx_d = fx_q;
    fy_d = fy_q;
    cx_d = cx_q;
    cy_d = cy_q;
    if (load_i) begin
      x_d  = cmd_x_i;
      y_d  = cmd_y_i;
      id_d = cmd_id_i;
      fx_d = '0;
      fy_d = '0;
      cx_d = '0;
      cy_d = '0;
    end else begin
      if (commit_adv_i) begin
        if (cx_q == XW'(SPRITE_W - 1)) begin
          cx_d = '0;
          cy_d = cy_q + YW'(1);
        end else begin
          cx_d = cx_q + XW'(1);
        end
      end
      // A pixel fetched but not committed (window closed) is fetched again from the commit point.
      if (replay_i) begin
        fx_d = cx_q;
        fy_d = cy_q;
      end else if (fetch_adv_i) begin
        if (fx_q == XW'(SPRITE_W - 1)) begin
          fx_d = '0;
          fy_d = fy_q + YW'(1);
        end else begin
          fx_d = fx_q + XW'(1);
        end
      end
    end
    // ROM address is registered from next-state counters so it is valid the cycle after a load.
    rom_addr_d = ROM_AW'(32'(id_d) * SPRITE_PIX + 32'(fy_d) * SPRITE_W + 32'(fx_d));
  end

  always_comb begin
    px            = 32'(x_q) + 32'(cx_q);
    py            = 32'(y_q) + 32'(cy_q);
    clip_o        = (px >= SCREEN_W) || (py >= SCREEN_H);
    fb_addr_o     = FB_AW'(py * SCREEN_W + px);
    rom_addr_o    = rom_addr_q;
    fetch_exh_o   = (fy_q == YW'(SPRITE_H));
    commit_last_o = (cx_q == XW'(SPRITE_W - 1)) && (cy_q == YW'(SPRITE_H - 1));
  end

endmodule

// File: rtl/sprite_blit_ctrl.sv
// Sprite blitter top: command handshake, IDLE/COPY/DONE sequencing and framebuffer
// write gating against the scanout write window.
module sprite_blit_ctrl
  import sprite_blit_ctrl_pkg::*;
#(
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480,
  parameter int unsigned SPRITE_W    = 32,
  parameter int unsigned SPRITE_H    = 48,
  parameter int unsigned ID_W        = 6,
  parameter int unsigned FB_AW       = 20,
  parameter int unsigned ROM_AW      = 17,
  parameter int unsigned PIX_W       = 9,
  parameter int unsigned TRANSPARENT = 0
) (
  input  logic                clk,
  input  logic                reset,
  sprite_blit_ctrl_if.slave   cmd,
  input  logic                write_window,
  output logic [ROM_AW-1:0]   rom_addr,
  input  logic [PIX_W-1:0]    rom_data,
  output logic [FB_AW-1:0]    fb_addr,
  output logic [PIX_W-1:0]    fb_data,
  output logic                fb_wEn,
  output logic                busy,
  output logic                done
);

  blit_state_e       state_q, state_d;
  logic              armed_q;
  logic              p_valid_q, p_valid_d;
  logic              ready;
  logic              accept;
  logic              in_copy;
  logic              commit_fire;
  logic              fetch_adv;
  logic              replay;
  logic              fetch_exh;
  logic              commit_last;
  logic              clip;
  logic [FB_AW-1:0]  pix_addr;

  sprite_blit_ctrl_addr_gen #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H),
    .ID_W     (ID_W),
    .FB_AW    (FB_AW),
    .ROM_AW   (ROM_AW)
  ) u_addr_gen (
    .clk           (clk),
    .rst_n         (reset),
    .load_i        (accept),
    .cmd_x_i       (cmd.cmd_x),
    .cmd_y_i       (cmd.cmd_y),
    .cmd_id_i      (cmd.cmd_id),
    .fetch_adv_i   (fetch_adv),
    .commit_adv_i  (commit_fire),
    .replay_i      (replay),
    .rom_addr_o    (rom_addr),
    .fb_addr_o     (pix_addr),
    .clip_o        (clip),
    .fetch_exh_o   (fetch_exh),
    .commit_last_o (commit_last)
  );

  // armed_q keeps cmd_ready low while reset is held and until the first edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      armed_q   <= 1'b0;
      p_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      armed_q   <= 1'b1;
      p_valid_q <= p_valid_d;
    end
  end

  always_comb begin
    in_copy     = (state_q == ST_COPY);
    accept      = cmd.cmd_valid && ready;
    commit_fire = in_copy && p_valid_q && write_window;
    fetch_adv   = in_copy && write_window && !fetch_exh;
    replay      = in_copy && p_valid_q && !write_window;
    p_valid_d   = in_copy && write_window && !fetch_exh;
    state_d     = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_COPY;
      ST_COPY: if (commit_fire && commit_last) state_d = ST_DONE;
      ST_DONE: state_d = accept ? ST_COPY : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready         = armed_q && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    cmd.cmd_ready = ready;
    busy          = (state_q == ST_COPY);
    done          = (state_q == ST_DONE);
    fb_wEn        = commit_fire && (rom_data != PIX_W'(TRANSPARENT)) && !clip;
    fb_addr       = fb_wEn ? pix_addr : '0;
    fb_data       = fb_wEn ? rom_data : '0;
  end

endmodule

// File: tb/tb_sprite_blit_ctrl.sv
// Scoreboard bench for sprite_blit_ctrl: stimulus pushes expected framebuffer writes,
// a negedge monitor pops and compares them and checks done latency.
module tb_sprite_blit_ctrl;
  import sprite_blit_ctrl_pkg::*;

  localparam int unsigned ID_W   = 6;
  localparam int unsigned ROM_AW = 17;
  localparam int unsigned FB_AW  = 20;
  localparam int unsigned PIX_W  = 9;
  localparam int          NPIX   = 1536;

  typedef struct packed {
    logic [FB_AW-1:0] addr;
    logic [PIX_W-1:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              write_window = 1'b1;
  logic [ROM_AW-1:0] rom_addr;
  logic [PIX_W-1:0]  rom_data = '0;
  logic [FB_AW-1:0]  fb_addr;
  logic [PIX_W-1:0]  fb_data;
  logic              fb_wEn;
  logic              busy;
  logic              done;

  sprite_blit_ctrl_if #(.ID_W(ID_W)) cmd_if();

  sprite_blit_ctrl #(
    .SCREEN_W(640), .SCREEN_H(480), .SPRITE_W(32), .SPRITE_H(48), .ID_W(ID_W),
    .FB_AW(FB_AW), .ROM_AW(ROM_AW), .PIX_W(PIX_W), .TRANSPARENT(0)
  ) dut (
    .clk(clk), .reset(reset), .cmd(cmd_if), .write_window(write_window),
    .rom_addr(rom_addr), .rom_data(rom_data), .fb_addr(fb_addr), .fb_data(fb_data),
    .fb_wEn(fb_wEn), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int  checks = 0, errors = 0;
  int  edge_cnt = 0;
  int  rom_mode = 0;
  bit  tog_en = 1'b0;
  int  ph = 0;
  wr_t exp_q[$];
  bit  timed_q[$];
  int  acc_q[$];
  int  last_acc = 0;
  int  wr_cnt = 0, first_edge = -1, last_edge = -1;
  logic [FB_AW-1:0] first_addr = '0, last_addr = '0;
  logic [PIX_W-1:0] first_data = '0, last_data = '0;

  // Mode 0: pixel = low address bits | 1, transparent where addr[3:0]==7.
  // Mode 1: only pixel 5 of sprite 2 is opaque (9'h1A7). Mode 2: every pixel 9'h055.
  function automatic logic [PIX_W-1:0] rom_fn(input logic [ROM_AW-1:0] a);
    case (rom_mode)
      0:       return (a[3:0] == 4'd7) ? 9'd0 : (a[8:0] | 9'd1);
      1:       return (a == ROM_AW'(2 * NPIX + 5)) ? 9'h1A7 : 9'd0;
      default: return 9'h055;
    endcase
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tog_en) begin
        write_window = (ph < 10);
        ph = (ph + 1) % 13;
      end else begin
        write_window = 1'b1;
        ph = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
        acc_q.push_back(edge_cnt + 1);
        last_acc = edge_cnt + 1;
      end
      if (fb_wEn) begin
        chk("wen_outside_window", 32'(write_window), 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d data 0x%0h expected no write", fb_addr, fb_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("fb_addr", 32'(fb_addr), 32'(e.addr));
          chk("fb_data", 32'(fb_data), 32'(e.data));
        end
        wr_cnt++;
        if (first_edge < 0) begin
          first_edge = edge_cnt;
          first_addr = fb_addr;
          first_data = fb_data;
        end
        last_edge = edge_cnt;
        last_addr = fb_addr;
        last_data = fb_data;
      end else begin
        chk("idle_bus_zero", 32'({fb_addr, fb_data}), 32'd0);
      end
      if (done) begin
        if (acc_q.size() == 0 || timed_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending command");
        end else begin
          int a;
          bit t;
          a = acc_q.pop_front();
          t = timed_q.pop_front();
          if (t) chk("done_latency", 32'(edge_cnt), 32'(a + NPIX + 1));
        end
      end
    end
  end

  task automatic push_model(input int x, input int y, input int id);
    for (int cy = 0; cy < 48; cy++) begin
      for (int cx = 0; cx < 32; cx++) begin
        logic [PIX_W-1:0] p;
        wr_t w;
        p = rom_fn(ROM_AW'(id * NPIX + cy * 32 + cx));
        if (p != 0 && (x + cx) < 640 && (y + cy) < 480) begin
          w.addr = FB_AW'((y + cy) * 640 + x + cx);
          w.data = p;
          exp_q.push_back(w);
        end
      end
    end
  endtask

  task automatic clr_stats();
    wr_cnt = 0;
    first_edge = -1;
    last_edge = -1;
  endtask

  task automatic issue(input int x, input int y, input int id, input bit timed, input bit hold);
    bit ok;
    push_model(x, y, id);
    timed_q.push_back(timed);
    @(posedge clk);
    #1;
    cmd_if.cmd_x = CMD_X_W'(x);
    cmd_if.cmd_y = CMD_Y_W'(y);
    cmd_if.cmd_id = ID_W'(id);
    cmd_if.cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (cmd_if.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (!hold) cmd_if.cmd_valid = 1'b0;
    chk("rom_addr_first", 32'(rom_addr), 32'(id * NPIX));
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_x = '0;
    cmd_if.cmd_y = '0;
    cmd_if.cmd_id = '0;

    // Reset state and release behaviour
    #3;
    chk("rst_cmd_ready", 32'(cmd_if.cmd_ready), 32'd0);
    chk("rst_outputs", 32'({busy, done, fb_wEn}), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;
    chk("ready_before_edge", 32'(cmd_if.cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("ready_after_edge", 32'(cmd_if.cmd_ready), 32'd1);

    // Sprite 1 at origin: latency and first/last write
    rom_mode = 0;
    clr_stats();
    issue(0, 0, 1, 1'b1, 1'b0);
    wait_done();
    chk("t2_first_lat", 32'(first_edge - last_acc), 32'd1);
    chk("t2_first_addr", 32'(first_addr), 32'd0);
    chk("t2_first_data", 32'(first_data), 32'd1);
    chk("t2_last_lat", 32'(last_edge - last_acc), 32'd1536);
    chk("t2_last_addr", 32'(last_addr), 32'd30111);
    chk("t2_last_data", 32'(last_data), 32'd511);
    chk("t2_wr_cnt", 32'(wr_cnt), 32'd1440);
    chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // Single opaque pixel
    rom_mode = 1;
    clr_stats();
    issue(100, 200, 2, 1'b1, 1'b0);
    wait_done();
    chk("t3_wr_cnt", 32'(wr_cnt), 32'd1);
    chk("t3_addr", 32'(first_addr), 32'd128105);
    chk("t3_data", 32'(first_data), 32'h1A7);

    // Bottom-right clipping
    rom_mode = 2;
    clr_stats();
    issue(620, 470, 3, 1'b1, 1'b0);
    wait_done();
    chk("t4_wr_cnt", 32'(wr_cnt), 32'd200);
    chk("t4_first_addr", 32'(first_addr), 32'd301420);
    chk("t4_last_addr", 32'(last_addr), 32'd307199);
    chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // Fully off-screen command
    clr_stats();
    issue(640, 100, 0, 1'b1, 1'b0);
    wait_done();
    chk("offscreen_wr_cnt", 32'(wr_cnt), 32'd0);

    // Write window toggling 10 on / 3 off
    rom_mode = 0;
    tog_en = 1'b1;
    clr_stats();
    issue(50, 60, 4, 1'b0, 1'b0);
    wait_done();
    tog_en = 1'b0;
    chk("t5_wr_cnt", 32'(wr_cnt), 32'd1440);
    chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    // Back-to-back: second command accepted in the done cycle
    rom_mode = 2;
    clr_stats();
    issue(0, 0, 0, 1'b1, 1'b1);
    push_model(608, 432, 9);
    timed_q.push_back(1'b1);
    cmd_if.cmd_x = 10'd608;
    cmd_if.cmd_y = 9'd432;
    cmd_if.cmd_id = 6'd9;
    wait_done();
    chk("t6_ready_in_done", 32'(cmd_if.cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    chk("t6_busy_after_done", 32'(busy), 32'd1);
    chk("t6_rom_addr_b", 32'(rom_addr), 32'(9 * NPIX));
    wait_done();
    chk("t6_wr_cnt", 32'(wr_cnt), 32'd3072);
    chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-COPY aborts immediately
    rom_mode = 0;
    issue(10, 10, 5, 1'b1, 1'b0);
    repeat (100) @(negedge clk);
    chk("t1_busy_before", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t1_wen_in_reset", 32'(fb_wEn), 32'd0);
    chk("t1_ready_in_reset", 32'(cmd_if.cmd_ready), 32'd0);
    chk("t1_busy_in_reset", 32'(busy), 32'd0);
    exp_q.delete();
    timed_q.delete();
    acc_q.delete();
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;
    chk("t1_ready_before_edge", 32'(cmd_if.cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("t1_ready_after_edge", 32'(cmd_if.cmd_ready), 32'd1);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
